// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch prefetch queue.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full queue is accepted only when a pop frees the slot.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ifetch_prefetch_queue.sv
// IF-stage fetch front end: single-outstanding memory reads feeding a prefetch queue,
// with stall hold and ID-stage redirect (flush + restart).
module ifetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt, hold_addr, hold_addr_nxt;
    logic         req, ack, push, pop, full, empty;
    logic [AW:0]  count, count_after;
    fetch_entry_t head, din;

    assign din = '{pc: fetch_pc, instr: mem_rdata_i};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        req           = 1'b0;
        push          = 1'b0;
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        hold_addr_nxt = hold_addr;
        case (state)
            IDLE:         req = ~full & ~redirect_i;
            REQ, DISCARD: req = 1'b1;
            default:      req = 1'b0;
        endcase
        if (reset) req = 1'b0;
        ack         = req & mem_ack_i;
        pop         = ~empty & ~stall_i & ~redirect_i;
        count_after = pop ? count : count + (AW+1)'(1);

        if (redirect_i) begin
            fetch_pc_nxt = {redirect_pc_i[31:2], 2'b00};
            if (state == IDLE || ack) begin
                state_nxt = IDLE;
            end else begin
                // Request stays on the bus at its old address; its data is thrown away.
                state_nxt = DISCARD;
                if (state == REQ) hold_addr_nxt = fetch_pc;
            end
        end else if (state == DISCARD) begin
            if (ack) state_nxt = IDLE;
        end else if (ack) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
            // Stay in REQ only while a free slot is reserved for the next response.
            state_nxt    = (count_after < (AW+1)'(DEPTH)) ? REQ : IDLE;
        end else if (req) begin
            state_nxt = REQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            hold_addr <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            hold_addr <= hold_addr_nxt;
        end
    end

    assign mem_req_o     = req;
    assign mem_addr_o    = !req ? 32'h0 : (state == DISCARD) ? hold_addr : fetch_pc;
    assign instr_valid_o = ~empty;
    assign instr_o       = empty ? NOP_INSTR : head.instr;
    assign pc_plus4_o    = empty ? 32'h0 : head.pc + 32'd4;
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed + random bench for ifetch_prefetch_queue against a queue-based reference model.
module tb_ifetch_prefetch_queue;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset, stall_i, redirect_i, mem_ack_i;
    logic [31:0] redirect_pc_i, mem_rdata_i;
    logic        mem_req_o, instr_valid_o;
    logic [31:0] mem_addr_o, instr_o, pc_plus4_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of fetched PCs plus the fetch/outstanding-request bookkeeping.
    logic [31:0] mq[$];
    logic [31:0] m_pc, m_oaddr;
    bit          m_out, m_disc;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign mem_rdata_i = mem_word(mem_addr_o);

    ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_oaddr = 32'h0;
        m_out   = 0;
        m_disc  = 0;
    endtask

    task automatic model_edge(input bit r, input bit a, input bit st, input bit rd,
                              input logic [31:0] rpc, input logic [31:0] addr);
        bit ackd;
        ackd = r & a;
        if (rd) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_out && !ackd) m_disc = 1;
            else begin m_out = 0; m_disc = 0; end
        end else begin
            if (mq.size() > 0 && !st) void'(mq.pop_front());
            if (ackd) begin
                if (m_disc) begin
                    m_out = 0; m_disc = 0;
                end else begin
                    mq.push_back(addr);
                    m_pc    = m_pc + 32'd4;
                    m_out   = (mq.size() < DEPTH);
                    m_oaddr = m_pc;
                end
            end else if (r) begin
                m_out = 1; m_oaddr = addr;
            end
        end
    endtask

    // Compare all outputs with the model, then advance one clock; inputs stay stable across the edge.
    task automatic tick();
        bit          exp_req, exp_v;
        logic [31:0] exp_addr;
        #1;
        exp_req  = m_out || (mq.size() < DEPTH && !redirect_i);
        exp_addr = exp_req ? (m_out ? m_oaddr : m_pc) : 32'h0;
        exp_v    = mq.size() > 0;
        chk("model_req",   {31'b0, mem_req_o},     {31'b0, exp_req});
        chk("model_addr",  mem_addr_o,             exp_addr);
        chk("model_valid", {31'b0, instr_valid_o}, {31'b0, exp_v});
        chk("model_instr", instr_o,    exp_v ? mem_word(mq[0]) : 32'h0);
        chk("model_pc4",   pc_plus4_o, exp_v ? mq[0] + 32'd4   : 32'h0);
        @(posedge CLK);
        model_edge(exp_req, mem_ack_i, stall_i, redirect_i, redirect_pc_i, exp_addr);
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] hd;
        reset = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0; mem_ack_i = 1;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        #1;
        chk("rst_req",   {31'b0, mem_req_o},     32'h0);
        chk("rst_addr",  mem_addr_o,             32'h0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o,                32'h0);
        chk("rst_pc4",   pc_plus4_o,             32'h0);
        reset = 0;

        // 1: streaming fetch, ack tied high
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t1_addr",  mem_addr_o, 32'(4 * i));
            chk("t1_valid", {31'b0, instr_valid_o}, (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) chk("t1_pc4", pc_plus4_o, 32'(4 * i));
            tick();
        end

        // 2: stall fills the queue, then drains in order
        hd = mq[0];
        stall_i = 1;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("t2_req_full", {31'b0, mem_req_o}, 32'h0);
        chk("t2_head",     pc_plus4_o, hd + 32'd4);
        stall_i = 0;
        tick();
        #1;
        chk("t2_resume", pc_plus4_o, hd + 32'd8);
        for (int i = 0; i < 6; i++) tick();

        // 3: redirect with a non-empty queue
        redirect_i = 1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 0;
        #1;
        chk("t3_valid0", {31'b0, instr_valid_o}, 32'h0);
        chk("t3_addr",   mem_addr_o, 32'h40);
        tick();
        #1;
        chk("t3_pc4",   pc_plus4_o, 32'h44);
        chk("t3_instr", instr_o,    mem_word(32'h40));
        tick();

        // 4: slow ack with a redirect while waiting
        redirect_i = 1; redirect_pc_i = 32'h200;
        tick();
        redirect_i = 0; mem_ack_i = 0;
        tick();
        redirect_i = 1; redirect_pc_i = 32'h80;
        #1; chk("t4_hold1", mem_addr_o, 32'h200);
        tick();
        redirect_i = 0;
        #1; chk("t4_hold2", mem_addr_o, 32'h200);
        tick();
        mem_ack_i = 1;
        #1; chk("t4_hold3", mem_addr_o, 32'h200);
        chk("t4_nodata", {31'b0, instr_valid_o}, 32'h0);
        tick();
        #1; chk("t4_new", mem_addr_o, 32'h80);
        chk("t4_valid0", {31'b0, instr_valid_o}, 32'h0);
        tick();
        #1; chk("t4_pc4", pc_plus4_o, 32'h84);
        tick();

        // 5: unaligned redirect target is word-aligned
        redirect_i = 1; redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 0;
        #1; chk("t5_align", mem_addr_o, 32'h100);
        tick();

        // 6: fetch PC wraps at the top of the address space
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 0;
        #1; chk("t6_top", mem_addr_o, 32'hFFFF_FFFC);
        tick();
        #1;
        chk("t6_wrap_addr", mem_addr_o, 32'h0);
        chk("t6_wrap_pc4",  pc_plus4_o, 32'h0);
        chk("t6_wrap_ins",  instr_o,    mem_word(32'hFFFF_FFFC));
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall_i       = ($urandom_range(0, 3) == 0);
            mem_ack_i     = ($urandom_range(0, 9) < 6);
            redirect_i    = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom();
            tick();
        end

        // Reset while a request is outstanding
        stall_i = 0; redirect_i = 0; mem_ack_i = 0;
        tick();
        tick();
        reset = 1;
        @(posedge CLK); @(negedge CLK);
        #1;
        chk("mrst_req",   {31'b0, mem_req_o},     32'h0);
        chk("mrst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("mrst_pc4",   pc_plus4_o,             32'h0);
        reset = 0; mem_ack_i = 1;
        model_reset();
        #1;
        chk("mrst_addr", mem_addr_o, 32'h0);
        for (int i = 0; i < 8; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
